// File: rtl/usb_ctrl_pkg.sv
// Shared USB controller definitions: byte width, TX arbiter FSM states and
// the sizing helper for the optional arbiter stall counter.
package usb_ctrl_pkg;

  localparam int USB_BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_ARB_IDLE      = 2'd0,
    TX_ARB_STREAM    = 2'd1,
    TX_ARB_WAIT_DONE = 2'd2
  } tx_arb_state_e;

  function automatic int tx_arb_cnt_w(input int timeout_cycles);
    return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_rr_picker.sv
// Combinational round-robin pick over requesters 1..NUM_REQ-1, starting at
// rr_ptr and wrapping back to 1. Requester 0 is never a candidate here.
module usb_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:1] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:1] pick,
  output logic               valid
);

  // NOTE: every output gets a default before any conditional write, so no
  // path through the block leaves a value held and no latch is inferred.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    // First pass covers rr_ptr..NUM_REQ-1, second pass the wrapped 1..rr_ptr-1.
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!valid && req[k] && (k >= int'(rr_ptr))) begin
        pick[k] = 1'b1;
        valid   = 1'b1;
      end
    end
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!valid && req[k]) begin
        pick[k] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Packet-granular arbiter sharing the SIE transmit byte stream: requester 0 has
// fixed priority, the rest rotate. Optional stall timeout: USB_TX_ARB_TIMEOUT_EN.
module usb_tx_arbiter
  import usb_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk48,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*USB_BYTE_W-1:0]    txData_i,
  input  logic [NUM_REQ-1:0]               txValid_i,
  input  logic [NUM_REQ-1:0]               txLast_i,
  output logic [NUM_REQ-1:0]               txReady_o,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic [USB_BYTE_W-1:0]            sieTxData_o,
  output logic                             sieTxValid_o,
  output logic                             sieTxLast_o,
  input  logic                             sieTxReady_i,
  input  logic                             sieTxDone_i,
  output logic                             busy_o,
  output logic                             abort_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("usb_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  tx_arb_state_e      state, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [PTR_W-1:0]   rr_ptr, rr_d, rr_next, owner;
  logic [NUM_REQ-1:1] rr_pick;
  logic               rr_valid;
  logic               xfer, done_release, timeout;

  usb_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req    (req_i[NUM_REQ-1:1]),
    .rr_ptr (rr_ptr),
    .pick   (rr_pick),
    .valid  (rr_valid)
  );

  always_comb begin
    owner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_o[k]) owner = PTR_W'(k);
    end
  end

  // Byte path is a pure mux of the owner; everything reads 0 outside STREAM.
  always_comb begin
    txReady_o    = '0;
    sieTxData_o  = '0;
    sieTxValid_o = 1'b0;
    sieTxLast_o  = 1'b0;
    if (state == TX_ARB_STREAM) begin
      sieTxData_o      = txData_i[owner*USB_BYTE_W +: USB_BYTE_W];
      sieTxValid_o     = txValid_i[owner];
      sieTxLast_o      = txLast_i[owner];
      txReady_o[owner] = sieTxReady_i;
    end
  end

  assign xfer    = sieTxValid_o & sieTxReady_i;
  assign rr_next = (owner == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : owner + PTR_W'(1);
  assign busy_o  = (state != TX_ARB_IDLE);

  always_comb begin
    state_d      = state;
    grant_d      = grant_o;
    rr_d         = rr_ptr;
    done_release = 1'b0;
    case (state)
      TX_ARB_IDLE: begin
        if (|req_i) begin
          state_d = TX_ARB_STREAM;
          grant_d = req_i[0] ? NUM_REQ'(1) : {rr_pick, 1'b0};
        end
      end
      TX_ARB_STREAM: begin
        if (xfer && sieTxLast_o) state_d = TX_ARB_WAIT_DONE;
      end
      TX_ARB_WAIT_DONE: begin
        if (sieTxDone_i) done_release = 1'b1;
      end
      default: state_d = TX_ARB_IDLE;
    endcase
    // Completion and timeout both hand the stream back the same way.
    if (done_release || timeout) begin
      state_d = TX_ARB_IDLE;
      grant_d = '0;
      if (owner != '0) rr_d = rr_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk48) begin
    if (rst) begin
      state   <= TX_ARB_IDLE;
      grant_o <= '0;
      rr_ptr  <= PTR_W'(1);
    end else begin
      state   <= state_d;
      grant_o <= grant_d;
      rr_ptr  <= rr_d;
    end
  end

`ifdef USB_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = tx_arb_cnt_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_cnt;

  // A completion arriving in the limit cycle wins over the timeout.
  assign timeout = (state != TX_ARB_IDLE) && !xfer &&
                   (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                   !((state == TX_ARB_WAIT_DONE) && sieTxDone_i);

  always_ff @(posedge clk48) begin
    if (rst) begin
      stall_cnt <= '0;
      abort_o   <= 1'b0;
    end else begin
      abort_o <= timeout;
      if ((state_d != state) || xfer || (state == TX_ARB_IDLE)) stall_cnt <= '0;
      else                                                      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort_o = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: packet-level reference model with
// directed scenarios followed by a randomized traffic phase.
module tb_usb_tx_arbiter;

  localparam int N = 4;
`ifdef USB_TX_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  typedef logic [7:0] bq_t[$];

  logic           clk48 = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i, txValid_i, txLast_i, txReady_o, grant_o;
  logic [N*8-1:0] txData_i;
  logic [7:0]     sieTxData_o;
  logic           sieTxValid_o, sieTxLast_o, sieTxReady_i, sieTxDone_i;
  logic           busy_o, abort_o;

  usb_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk48        (clk48),
    .rst          (rst),
    .req_i        (req_i),
    .txData_i     (txData_i),
    .txValid_i    (txValid_i),
    .txLast_i     (txLast_i),
    .txReady_o    (txReady_o),
    .grant_o      (grant_o),
    .sieTxData_o  (sieTxData_o),
    .sieTxValid_o (sieTxValid_o),
    .sieTxLast_o  (sieTxLast_o),
    .sieTxReady_i (sieTxReady_i),
    .sieTxDone_i  (sieTxDone_i),
    .busy_o       (busy_o),
    .abort_o      (abort_o)
  );

  always #5 clk48 = ~clk48;

  int n_cmp = 0, n_err = 0, cyc = 0, n_abort_obs = 0;

  // Reference model: per-source packet queues plus packet-level ownership.
  bq_t      pkt [N];
  bq_t      exp_pkt [N];
  bq_t      rx_q;
  bit       pend [N];
  int       owner = -1, rr = 1, done_cnt = 0, stall = 0;
  bit       last_sent = 1'b0, abort_exp = 1'b0;
  int       valid_pct = 100, ready_pct = 100, refill_pct = 0, stray_pct = 0;
  bit [N-1:0] refill_mask = '0;
  bit       rdy_pat[$];
  int       order_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    if (r[0]) return 0;
    for (int i = 0; i < N - 1; i++) begin
      int c;
      c = (p - 1 + i) % (N - 1) + 1;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit any_pend();
    for (int k = 0; k < N; k++) if (pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic new_pkt(input int k, input int len);
    logic [7:0] b;
    pkt[k].delete();
    exp_pkt[k].delete();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt[k].push_back(b);
      exp_pkt[k].push_back(b);
    end
    pend[k] = 1'b1;
  endtask

  task automatic release_owner();
    if (owner != 0) rr = (owner == N - 1) ? 1 : owner + 1;
    owner     = -1;
    last_sent = 1'b0;
    done_cnt  = 0;
  endtask

  task automatic cycle();
    logic         done, xfer, strm;
    logic [N-1:0] exp_grant, exp_rdy;
    int           w;
    @(posedge clk48);
    #1;
    cyc++;
    for (int k = 0; k < N; k++)
      if (refill_mask[k] && !pend[k] && ($urandom_range(99) < refill_pct))
        new_pkt(k, $urandom_range(1, 6));
    for (int k = 0; k < N; k++) begin
      req_i[k]        = pend[k];
      txValid_i[k]    = pend[k] && ($urandom_range(99) < valid_pct);
      txData_i[k*8 +: 8] = (pkt[k].size() > 0) ? pkt[k][0] : 8'($urandom);
      txLast_i[k]     = pend[k] && (pkt[k].size() == 1);
    end
    sieTxReady_i = (rdy_pat.size() > 0) ? rdy_pat[cyc % rdy_pat.size()]
                                        : ($urandom_range(99) < ready_pct);
    done = (done_cnt == 1) ||
           (!(owner >= 0 && last_sent) && ($urandom_range(99) < stray_pct));
    if (done_cnt > 0) done_cnt--;
    sieTxDone_i = done;

    @(negedge clk48);
    strm      = (owner >= 0) && !last_sent;
    exp_grant = (owner >= 0) ? (N'(1) << owner) : '0;
    exp_rdy   = strm ? (N'(sieTxReady_i) << owner) : '0;
    check("grant", grant_o, exp_grant);
    check("busy", busy_o, owner >= 0);
    check("abort", abort_o, abort_exp);
    check("tx_ready", txReady_o, exp_rdy);
    check("sie_valid", sieTxValid_o, strm ? txValid_i[owner] : 1'b0);
    check("sie_last", sieTxLast_o, strm ? txLast_i[owner] : 1'b0);
    check("sie_data", sieTxData_o, strm ? txData_i[owner*8 +: 8] : 8'h00);
    if (abort_o) n_abort_obs++;

    xfer      = strm && txValid_i[owner] && sieTxReady_i;
    abort_exp = 1'b0;
    if (owner < 0) begin
      w = pick(req_i, rr);
      if (w >= 0) begin
        owner     = w;
        last_sent = 1'b0;
        stall     = 0;
        order_q.push_back(w);
        rx_q.delete();
      end
    end else if (last_sent && done) begin
      release_owner();
`ifdef USB_TX_ARB_TIMEOUT_EN
    end else if (!xfer && stall == TO - 1) begin
      abort_exp  = 1'b1;
      pend[owner] = 1'b0;
      pkt[owner].delete();
      release_owner();
`endif
    end else if (xfer) begin
      rx_q.push_back(sieTxData_o);
      void'(pkt[owner].pop_front());
      stall = 0;
      if (txLast_i[owner]) begin
        last_sent   = 1'b1;
        pend[owner] = 1'b0;
        done_cnt    = $urandom_range(1, 4);
        check("pkt_len", rx_q.size(), exp_pkt[owner].size());
        for (int i = 0; i < rx_q.size() && i < exp_pkt[owner].size(); i++)
          check("pkt_byte", rx_q[i], exp_pkt[owner][i]);
      end
    end else begin
      stall++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk48);
    #1;
    rst = 1'b1;
    req_i = '0; txValid_i = '0; txLast_i = '0; txData_i = '0;
    sieTxReady_i = 1'b0; sieTxDone_i = 1'b0;
    @(posedge clk48);
    #1;
    rst = 1'b0;
    @(negedge clk48);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_abort", abort_o, 0);
    check("rst_tx_ready", txReady_o, 0);
    check("rst_sie_valid", sieTxValid_o, 0);
    check("rst_sie_last", sieTxLast_o, 0);
    check("rst_sie_data", sieTxData_o, 0);
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      pkt[k].delete();
    end
    owner = -1; rr = 1; last_sent = 1'b0; done_cnt = 0; abort_exp = 1'b0; stall = 0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (owner < 0 && !any_pend()) break;
      cycle();
    end
    check("drain_done", (owner < 0 && !any_pend()), 1);
  endtask

  task automatic check_order(input string tag, input int e[$]);
    check({tag, "_len"}, order_q.size() >= e.size(), 1);
    for (int i = 0; i < e.size() && i < order_q.size(); i++)
      check({tag, "_owner"}, order_q[i], e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_ord[$];
    rst = 1'b1;
    req_i = '0; txValid_i = '0; txLast_i = '0; txData_i = '0;
    sieTxReady_i = 1'b0; sieTxDone_i = 1'b0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;

    // Reset state, then simultaneous requests 0,1,2 from rrPtr=1.
    do_reset();
    new_pkt(0, 2); new_pkt(1, 3); new_pkt(2, 2);
    order_q.delete();
    drain(100);
    exp_ord = '{0, 1, 2};
    check_order("priority", exp_ord);

    // Single 3-byte packet from requester 1.
    order_q.delete();
    new_pkt(1, 3);
    drain(50);
    exp_ord = '{1};
    check_order("single", exp_ord);

    // Round-robin with requesters 1..3 re-requesting continuously.
    do_reset();
    order_q.delete();
    refill_mask = 4'b1110;
    refill_pct  = 100;
    for (int i = 0; i < 300 && order_q.size() < 6; i++) cycle();
    refill_pct = 0;
    drain(200);
    exp_ord = '{1, 2, 3, 1, 2, 3};
    check_order("round_robin", exp_ord);

    // Backpressure with a 1,0,0,1 ready pattern; a second source waits.
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    new_pkt(2, 6); new_pkt(3, 4);
    drain(200);
    rdy_pat.delete();

    // Reset after byte 2 of 5, then a fresh packet starting at byte 0.
    new_pkt(1, 5);
    for (int i = 0; i < 20 && pkt[1].size() > 3; i++) cycle();
    check("mid_progress", pkt[1].size(), 3);
    do_reset();
    order_q.delete();
    new_pkt(1, 5);
    drain(50);
    exp_ord = '{1};
    check_order("after_reset", exp_ord);

    // Owner stalls with txValid_i low.
    do_reset();
    order_q.delete();
    n_abort_obs = 0;
    valid_pct = 0;
    new_pkt(1, 3); new_pkt(2, 2);
`ifdef USB_TX_ARB_TIMEOUT_EN
    repeat (20) cycle();
    exp_ord = '{1, 2};
    check_order("timeout_move", exp_ord);
    check("timeout_aborts", n_abort_obs, 1);
`else
    repeat (40) cycle();
    check("stall_hold", order_q.size(), 1);
    check("stall_no_abort", n_abort_obs, 0);
`endif
    valid_pct = 100;
    drain(100);

    // Randomized traffic with stray done pulses.
    refill_mask = '1;
    refill_pct  = 30;
    valid_pct   = 80;
    ready_pct   = 75;
    stray_pct   = 5;
    repeat (3000) cycle();
    refill_pct = 0;
    stray_pct  = 0;
    valid_pct  = 100;
    drain(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
